// File: rtl/pa_bus.sv
// Shared constants, state encoding and access record for the CPU external bus controller.
package pa_bus;

    localparam int unsigned ADDR_W  = 22;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned TMO_W   = 8;
    localparam int unsigned STATE_W = 3;

    localparam int unsigned WAIT_MEM_DEF     = 1;
    localparam int unsigned WAIT_IO_DEF      = 3;
    localparam int unsigned WAIT_TIMEOUT_DEF = 255;

    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_SETUP   = 3'd1;
    localparam logic [STATE_W-1:0] ST_STROBE  = 3'd2;
    localparam logic [STATE_W-1:0] ST_RECOVER = 3'd3;
    localparam logic [STATE_W-1:0] ST_DMA     = 3'd4;

    // CPU request as latched at acceptance; held stable for the whole access.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              mem_io;
        logic              rd;
        logic              wr;
        logic [DATA_W-1:0] wdata;
    } access_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level, cleared by arst.
module sync2 (
    input  logic clk,
    input  logic arst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/bus_controller.sv
// CPU-to-external-bus controller: setup/strobe/recover cycle with programmable waits,
// slave wait extension with timeout, and DMA bus hand-off between accesses.
module bus_controller
    import pa_bus::*;
#(
    parameter int unsigned WAIT_MEM     = WAIT_MEM_DEF,
    parameter int unsigned WAIT_IO      = WAIT_IO_DEF,
    parameter int unsigned WAIT_TIMEOUT = WAIT_TIMEOUT_DEF
) (
    input  logic              arst,
    input  logic              clk,
    input  logic              cpu_req,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic              cpu_mem_io,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              bus_err,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_mem_io,
    output logic              bus_rd_n,
    output logic              bus_wr_n,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_wdata_oe,
    output logic              bus_oe,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              ext_wait,
    input  logic              dma_req,
    output logic              dma_ack
);

    logic               wait_s;
    logic               dma_s;

    logic [STATE_W-1:0] state,      state_nx;
    logic [CNT_W-1:0]   cnt,        cnt_nx;
    logic [TMO_W-1:0]   tmo,        tmo_nx;
    access_t            acc,        acc_nx;
    logic               rd_n_nx,    wr_n_nx;
    logic               oe_nx,      wdata_oe_nx;
    logic               ack_nx,     ready_nx,    err_nx;
    logic [DATA_W-1:0]  rdata_nx;

    sync2 u_sync_wait (.clk(clk), .arst(arst), .d(ext_wait), .q(wait_s));
    sync2 u_sync_dma  (.clk(clk), .arst(arst), .d(dma_req),  .q(dma_s));

    assign bus_addr   = acc.addr;
    assign bus_mem_io = acc.mem_io;
    assign bus_wdata  = acc.wdata;

    // Next state plus next value of every registered bus/CPU output.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        tmo_nx      = tmo;
        acc_nx      = acc;
        rd_n_nx     = 1'b1;
        wr_n_nx     = 1'b1;
        oe_nx       = 1'b1;
        wdata_oe_nx = 1'b0;
        ack_nx      = 1'b0;
        ready_nx    = 1'b0;
        err_nx      = 1'b0;
        rdata_nx    = cpu_rdata;

        case (state)
            ST_IDLE: begin
                if (dma_s) begin
                    state_nx = ST_DMA;
                    ack_nx   = 1'b1;
                    oe_nx    = 1'b0;
                end else if (cpu_req) begin
                    acc_nx = '{addr: cpu_addr, mem_io: cpu_mem_io, rd: cpu_rd,
                               wr: cpu_wr, wdata: cpu_wdata};
                    if (cpu_rd == cpu_wr) begin
                        state_nx = ST_RECOVER;
                        ready_nx = 1'b1;
                        err_nx   = 1'b1;
                    end else begin
                        state_nx    = ST_SETUP;
                        wdata_oe_nx = cpu_wr;
                    end
                end
            end
            ST_SETUP: begin
                state_nx    = ST_STROBE;
                cnt_nx      = acc.mem_io ? CNT_W'(WAIT_MEM) : CNT_W'(WAIT_IO);
                tmo_nx      = '0;
                rd_n_nx     = ~acc.rd;
                wr_n_nx     = ~acc.wr;
                wdata_oe_nx = acc.wr;
            end
            ST_STROBE: begin
                wdata_oe_nx = acc.wr;
                if (cnt != '0) begin
                    cnt_nx  = cnt - CNT_W'(1);
                    rd_n_nx = ~acc.rd;
                    wr_n_nx = ~acc.wr;
                end else if (wait_s && (tmo != TMO_W'(WAIT_TIMEOUT))) begin
                    tmo_nx  = tmo + TMO_W'(1);
                    rd_n_nx = ~acc.rd;
                    wr_n_nx = ~acc.wr;
                end else if (wait_s) begin
                    // Slave never released wait: abort with an all-ones read value.
                    state_nx = ST_RECOVER;
                    ready_nx = 1'b1;
                    err_nx   = 1'b1;
                    rdata_nx = '1;
                end else begin
                    state_nx = ST_RECOVER;
                    ready_nx = 1'b1;
                    if (acc.rd) begin
                        rdata_nx = bus_rdata;
                    end
                end
            end
            ST_RECOVER: begin
                state_nx = ST_IDLE;
            end
            ST_DMA: begin
                if (dma_s) begin
                    ack_nx = 1'b1;
                    oe_nx  = 1'b0;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            tmo          <= '0;
            acc          <= '0;
            bus_rd_n     <= 1'b1;
            bus_wr_n     <= 1'b1;
            bus_oe       <= 1'b1;
            bus_wdata_oe <= 1'b0;
            dma_ack      <= 1'b0;
            cpu_ready    <= 1'b0;
            bus_err      <= 1'b0;
            cpu_rdata    <= '0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            tmo          <= tmo_nx;
            acc          <= acc_nx;
            bus_rd_n     <= rd_n_nx;
            bus_wr_n     <= wr_n_nx;
            bus_oe       <= oe_nx;
            bus_wdata_oe <= wdata_oe_nx;
            dma_ack      <= ack_nx;
            cpu_ready    <= ready_nx;
            bus_err      <= err_nx;
            cpu_rdata    <= rdata_nx;
        end
    end

endmodule

// File: tb/tb_bus_controller.sv
// Scoreboard bench for bus_controller: directed corner cases plus randomized accesses,
// expected results computed from cycle-level rules of the bus protocol.
module tb_bus_controller;

    localparam int WM = 1;
    localparam int WI = 3;
    localparam int WT = 255;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        cpu_req = 1'b0, cpu_rd = 1'b0, cpu_wr = 1'b0, cpu_mem_io = 1'b0;
    logic [21:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic [7:0]  cpu_rdata;
    logic        cpu_ready, bus_err;
    logic [21:0] bus_addr;
    logic        bus_mem_io, bus_rd_n, bus_wr_n;
    logic [7:0]  bus_wdata;
    logic        bus_wdata_oe, bus_oe;
    logic [7:0]  bus_rdata = '0;
    logic        ext_wait = 1'b0, dma_req = 1'b0;
    logic        dma_ack;

    bus_controller #(.WAIT_MEM(WM), .WAIT_IO(WI), .WAIT_TIMEOUT(WT)) dut (
        .arst(arst), .clk(clk),
        .cpu_req(cpu_req), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_mem_io(cpu_mem_io),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready), .bus_err(bus_err),
        .bus_addr(bus_addr), .bus_mem_io(bus_mem_io), .bus_rd_n(bus_rd_n), .bus_wr_n(bus_wr_n),
        .bus_wdata(bus_wdata), .bus_wdata_oe(bus_wdata_oe), .bus_oe(bus_oe),
        .bus_rdata(bus_rdata), .ext_wait(ext_wait), .dma_req(dma_req), .dma_ack(dma_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [21:0] addr;
        logic        mem_io;
        logic        rd;
        logic        wr;
        logic [7:0]  wdata;
        int          len;
        int          lat;
        logic        err;
        logic        chk_rdata;
        logic [7:0]  rdata;
        int          accept;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: wait_s lags ext_wait by two cycles; ext_wait raised with the request for
    // wlen cycles therefore stretches the strobe by wlen-W cycles, aborting past WT.
    function automatic exp_t model(input logic [21:0] addr, input logic mem_io, input logic rd,
                                   input logic wr, input logic [7:0] wdata, input int wlen,
                                   input logic [7:0] rv, input int acc);
        exp_t e;
        int   w;
        int   ext;
        w = mem_io ? WM : WI;
        e.addr = addr; e.mem_io = mem_io; e.rd = rd; e.wr = wr; e.wdata = wdata;
        e.accept = acc; e.rdata = rv; e.chk_rdata = 1'b0;
        if (rd == wr) begin
            e.len = 0; e.lat = 1; e.err = 1'b1;
        end else begin
            ext = (wlen > w) ? wlen - w : 0;
            if (ext > WT) begin
                e.len = 1 + w + WT; e.err = 1'b1; e.rdata = 8'hFF;
            end else begin
                e.len = 1 + w + ext; e.err = 1'b0;
            end
            e.lat = e.len + 2;
            e.chk_rdata = rd;
        end
        return e;
    endfunction

    // Monitor: measures strobes and compares every completion against the scoreboard.
    int   slen = 0;
    logic srd = 1'b0, swr = 1'b0, oe_bad = 1'b0;
    exp_t me;
    always @(negedge clk) begin
        if (arst) begin
            slen = 0; srd = 1'b0; swr = 1'b0; oe_bad = 1'b0;
        end else begin
            if (!bus_rd_n || !bus_wr_n) begin
                slen++;
                if (!bus_rd_n) srd = 1'b1;
                if (!bus_wr_n) swr = 1'b1;
                if (!bus_wr_n && !bus_wdata_oe) oe_bad = 1'b1;
            end
            if (dma_ack) begin
                check("dma_bus_oe", 32'(bus_oe), 32'd0);
                check("dma_strobes_oe", 32'({bus_rd_n, bus_wr_n, bus_wdata_oe}), 32'b110);
            end
            if (bus_err && !cpu_ready) check("err_without_ready", 32'(cpu_ready), 32'd1);
            if (cpu_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", 32'(cpu_ready), 32'd0);
                end else begin
                    me = exp_q.pop_front();
                    check("latency", 32'(cyc - me.accept), 32'(me.lat));
                    check("strobe_len", 32'(slen), 32'(me.len));
                    check("strobe_kind", 32'({srd, swr}),
                          32'((me.rd != me.wr) ? {me.rd, me.wr} : 2'b00));
                    check("bus_addr", 32'(bus_addr), 32'(me.addr));
                    check("bus_mem_io", 32'(bus_mem_io), 32'(me.mem_io));
                    check("bus_err", 32'(bus_err), 32'(me.err));
                    if (me.chk_rdata) check("cpu_rdata", 32'(cpu_rdata), 32'(me.rdata));
                    if (me.wr && !me.rd) begin
                        check("bus_wdata", 32'(bus_wdata), 32'(me.wdata));
                        check("wdata_oe_recover", 32'(bus_wdata_oe), 32'd1);
                        check("wdata_oe_strobe", 32'(oe_bad), 32'd0);
                    end
                end
                slen = 0; srd = 1'b0; swr = 1'b0; oe_bad = 1'b0;
            end
        end
    end

    task automatic wait_ready(input int budget);
        int k;
        k = 0;
        @(negedge clk);
        while (!cpu_ready && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!cpu_ready) check("ready_timeout", 32'(cpu_ready), 32'd1);
    endtask

    // Issue one access from IDLE (called just after a rising edge); cpu inputs are scrambled
    // once accepted, since only the latched copy may matter.
    task automatic do_tx(input logic [21:0] addr, input logic mem_io, input logic rd,
                         input logic wr, input logic [7:0] wdata, input int wlen,
                         input logic [7:0] rv);
        int k;
        bit done;
        cpu_req = 1'b1; cpu_addr = addr; cpu_mem_io = mem_io; cpu_rd = rd; cpu_wr = wr;
        cpu_wdata = wdata; bus_rdata = rv; ext_wait = (wlen > 0);
        exp_q.push_back(model(addr, mem_io, rd, wr, wdata, wlen, rv, cyc));
        k = 0; done = 1'b0;
        while (!done && k < 600) begin
            @(posedge clk); #1;
            k++;
            if (k == wlen) ext_wait = 1'b0;
            cpu_req = 1'($urandom); cpu_rd = 1'($urandom); cpu_wr = 1'($urandom);
            cpu_mem_io = 1'($urandom); cpu_addr = 22'($urandom); cpu_wdata = 8'($urandom);
            @(negedge clk);
            if (cpu_ready) done = 1'b1;
        end
        if (!done) check("ready_timeout", 32'(cpu_ready), 32'd1);
        @(posedge clk); #1;
        cpu_req = 1'b0; ext_wait = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wl;
        int r;
        repeat (3) @(negedge clk);
        check("reset_ctrl", 32'({bus_rd_n, bus_wr_n, bus_oe, bus_wdata_oe, dma_ack, cpu_ready, bus_err}),
              32'b1110000);
        check("reset_addr", 32'(bus_addr), 32'd0);
        check("reset_wdata", 32'(bus_wdata), 32'd0);
        check("reset_rdata", 32'(cpu_rdata), 32'd0);
        arst = 1'b0;
        @(posedge clk); #1;

        do_tx(22'h12345, 1'b1, 1'b1, 1'b0, 8'h00, 0, 8'hA5);
        do_tx(22'h00040, 1'b0, 1'b0, 1'b1, 8'h3C, 0, 8'h00);
        do_tx(22'h0ABCD, 1'b1, 1'b1, 1'b0, 8'h00, 10, 8'h77);
        do_tx(22'h1F000, 1'b1, 1'b1, 1'b0, 8'h00, 400, 8'h12);
        do_tx(22'h00123, 1'b1, 1'b1, 1'b0, 8'h00, WT + WM, 8'h34);
        do_tx(22'h00124, 1'b1, 1'b1, 1'b0, 8'h00, WT + WM + 1, 8'h56);
        do_tx(22'h00555, 1'b0, 1'b1, 1'b1, 8'h11, 0, 8'h00);
        do_tx(22'h00AAA, 1'b1, 1'b0, 1'b0, 8'h22, 0, 8'h00);

        // DMA requested mid-access: held off until IDLE, then wins over a pending CPU request.
        cpu_req = 1'b1; cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_mem_io = 1'b0;
        cpu_addr = 22'h2A5A5; bus_rdata = 8'h5E;
        exp_q.push_back(model(22'h2A5A5, 1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h5E, cyc));
        repeat (2) @(posedge clk);
        #1 dma_req = 1'b1;
        wait_ready(50);
        check("dma_held_off", 32'(dma_ack), 32'd0);
        @(posedge clk); #1;
        cpu_mem_io = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_addr = 22'h3FFFF; cpu_wdata = 8'h96;
        @(negedge clk);
        check("dma_not_yet", 32'(dma_ack), 32'd0);
        repeat (4) begin
            @(negedge clk);
            check("dma_ack_high", 32'(dma_ack), 32'd1);
        end
        @(posedge clk); #1;
        dma_req = 1'b0;
        exp_q.push_back(model(22'h3FFFF, 1'b1, 1'b0, 1'b1, 8'h96, 0, 8'h00, cyc + 3));
        repeat (3) begin
            @(negedge clk);
            check("dma_ack_hold", 32'(dma_ack), 32'd1);
        end
        @(negedge clk);
        check("dma_ack_release", 32'(dma_ack), 32'd0);
        wait_ready(50);
        @(posedge clk); #1;
        cpu_req = 1'b0;

        // Reset in the middle of a strobe aborts the access without a completion.
        cpu_req = 1'b1; cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_mem_io = 1'b0; cpu_addr = 22'h01010;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("strobe_before_reset", 32'(bus_rd_n), 32'd0);
        #2 arst = 1'b1;
        #1 check("async_strobe_release", 32'({bus_rd_n, bus_wr_n, cpu_ready}), 32'b110);
        exp_q.delete();
        cpu_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("no_ready_in_reset", 32'(cpu_ready), 32'd0);
        end
        arst = 1'b0;
        @(posedge clk); #1;
        do_tx(22'h12345, 1'b1, 1'b1, 1'b0, 8'h00, 0, 8'hC3);

        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 19));
            if (r < 10) wl = 0;
            else if (r < 19) wl = int'($urandom_range(1, 20));
            else wl = 300;
            r = int'($urandom_range(0, 7));
            do_tx(22'($urandom), 1'($urandom),
                  (r == 0) ? 1'b1 : ((r < 4) ? 1'b1 : 1'b0),
                  (r == 0) ? 1'b1 : ((r < 4) ? 1'b0 : 1'b1),
                  8'($urandom), wl, 8'($urandom));
            repeat (int'($urandom_range(0, 2))) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
